memory_access_unit: RTL and testbench

- Sequencer between the CPU datapath bus and the synchronous 512x32 RAM.
- Holds MAR and MDR and runs a fixed read or write transaction against the RAM.
- Drives the RAM's address, read, write and data_input pins; captures the RAM's registered data_output into MDR.
- Reports busy and a one-cycle done pulse to the control unit.

---
 rtl/memory_access_unit_pkg.sv | 24 ++
 rtl/memory_access_unit_enable_register.sv | 31 +++
 rtl/memory_access_unit.sv | 139 +++++++++++++
 tb/tb_memory_access_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   - Default address/data widths for the 512x32 synchronous RAM.
//   - FSM state encoding (3 bits, fixed values so debug dumps are stable).
//   - Helper that tells whether MAR/MDR may be loaded from the bus.
package memory_access_unit_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ISSUE   = 3'd1,
    ST_RD_CAPTURE = 3'd2,
    ST_WR_ISSUE   = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // Bus loads are only honoured outside an active RAM access, so the
  // address and write data stay frozen while the RAM is being driven.
  function automatic logic regs_loadable(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/memory_access_unit_enable_register.sv
// Generic load-enabled register with asynchronous active-low clear.
// Used for both MAR and MDR.
// Ports:
//   clk    - clock, loads on posedge
//   clr_n  - asynchronous active-low clear (q -> 0)
//   i_load - load enable
//   i_d    - data to load
//   o_q    - register contents
module enable_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/memory_access_unit.sv
// Sequencer between the CPU datapath bus and a synchronous 512x32 RAM.
// Holds MAR/MDR and runs a fixed read (3 cycles) or write (2 cycles)
// transaction, reporting busy and a one-cycle done pulse.
// Handshake: read_req/write_req are sampled only in IDLE; a single-cycle
// pulse is enough, requests in any other state are dropped (not queued),
// and write wins if both are raised together. done is a one-cycle pulse
// marking completion; busy is high in every state except IDLE.
// Ports:
//   clk, clr_n            - clock, asynchronous active-low reset
//   bus_in                - datapath bus
//   mar_in, mdr_in        - load MAR (low address bits) / MDR from bus_in
//   read_req, write_req   - start a RAM read into MDR / write of MDR
//   mdr_out               - MDR contents
//   ram_address           - MAR, combinational
//   ram_read, ram_write   - RAM strobes
//   ram_data_out          - MDR, to RAM data_input
//   ram_data_in           - RAM registered data_output
//   busy, done            - status to the control unit
//   state_dbg             - current FSM state (debug visibility)
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mar_in,
  input  logic                  mdr_in,
  input  logic                  read_req,
  input  logic                  write_req,
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  state_t r_state;
  logic   r_ram_read;
  logic   r_ram_write;
  logic   r_busy;
  logic   r_done;

  logic                  w_capture;
  logic                  w_mar_load;
  logic                  w_mdr_load;
  logic [DATA_WIDTH-1:0] w_mdr_d;
  logic [ADDR_WIDTH-1:0] w_mar_q;
  logic [DATA_WIDTH-1:0] w_mdr_q;

  // The RAM output is only meaningful on the RD_CAPTURE edge; at any other
  // time it is undefined, so MDR must never take it otherwise.
  assign w_capture  = (r_state == ST_RD_CAPTURE);
  assign w_mar_load = mar_in && regs_loadable(r_state);
  assign w_mdr_load = w_capture || (mdr_in && regs_loadable(r_state));
  assign w_mdr_d    = w_capture ? ram_data_in : bus_in;

  enable_register #(.WIDTH(ADDR_WIDTH)) u_mar (
    .clk    (clk),
    .clr_n  (clr_n),
    .i_load (w_mar_load),
    .i_d    (bus_in[ADDR_WIDTH-1:0]),
    .o_q    (w_mar_q)
  );

  enable_register #(.WIDTH(DATA_WIDTH)) u_mdr (
    .clk    (clk),
    .clr_n  (clr_n),
    .i_load (w_mdr_load),
    .i_d    (w_mdr_d),
    .o_q    (w_mdr_q)
  );

  // Outputs are registered alongside the state: each branch sets the
  // Moore decode of the state it is moving into.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= ST_IDLE;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (write_req) begin
            r_state     <= ST_WR_ISSUE;
            r_ram_write <= 1'b1;
          end else if (read_req) begin
            r_state    <= ST_RD_ISSUE;
            r_ram_read <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RD_ISSUE: begin
          r_state <= ST_RD_CAPTURE;
        end
        ST_RD_CAPTURE: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_WR_ISSUE: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mdr_out      = w_mdr_q;
  assign ram_data_out = w_mdr_q;
  assign ram_address  = w_mar_q;
  assign ram_read     = r_ram_read;
  assign ram_write    = r_ram_write;
  assign busy         = r_busy;
  assign done         = r_done;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NV = 12;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          mar_in = 1'b0;
  logic          mdr_in = 1'b0;
  logic          read_req = 1'b0;
  logic          write_req = 1'b0;
  logic [DW-1:0] mdr_out;
  logic [AW-1:0] ram_address;
  logic          ram_read;
  logic          ram_write;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] ram_data_in;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;

  memory_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .bus_in       (bus_in),
    .mar_in       (mar_in),
    .mdr_in       (mdr_in),
    .read_req     (read_req),
    .write_req    (write_req),
    .mdr_out      (mdr_out),
    .ram_address  (ram_address),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_data_out (ram_data_out),
    .ram_data_in  (ram_data_in),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  // Registered output; a recognisable garbage pattern stands in for the
  // undefined output whenever read is low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_data_out;
    if (ram_read) ram_data_in <= mem[ram_address];
    else          ram_data_in <= 32'hBADC_0FFE;
  end

  // ---------------- strobe monitors ----------------
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  always @(posedge clk) begin
    if (ram_write) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= ram_address;
      wr_data <= ram_data_out;
    end
    if (ram_read) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= ram_address;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic pop_check(input string name);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, mdr_out, e);
    end
  endtask

  // ---------------- driver tasks (start/end just after a negedge) ----------------
  task automatic load_mar(input logic [DW-1:0] v);
    bus_in = v; mar_in = 1'b1;
    @(negedge clk);
    mar_in = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    bus_in = v; mdr_in = 1'b1;
    @(negedge clk);
    mdr_in = 1'b0;
  endtask

  // Pulses the request(s) for one edge, then returns the index of the
  // negedge after the request edge at which done is seen (0 = timeout).
  // Ends one cycle after done, i.e. back in IDLE.
  task automatic run_op(input logic wr, input logic rd, input logic ld_mar,
                        input logic ld_mdr, input logic [DW-1:0] bus, output int lat);
    bus_in = bus; mar_in = ld_mar; mdr_in = ld_mdr;
    write_req = wr; read_req = rd;
    @(negedge clk);
    write_req = 1'b0; read_req = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      if (rd && !wr) pop_check("rd_mdr");
      @(negedge clk);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [DW-1:0] mar_bus;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int lat;
    int w0, r0, d0;
    logic [AW-1:0] a;

    vecs[0]  = '{1'b1, 32'h0000_0055, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 32'h0000_0055, 32'h0};
    vecs[2]  = '{1'b1, 32'hFFFF_FE03, 32'hA5A5_5A5A};
    vecs[3]  = '{1'b0, 32'hFFFF_FE03, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[5]  = '{1'b1, 32'h0000_01FE, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_01FE, 32'h0};
    for (int i = 8; i < NV; i += 2) begin
      vecs[i]   = '{1'b1, $urandom(), $urandom()};
      vecs[i+1] = '{1'b0, vecs[i].mar_bus, 32'h0};
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_read", 32'(ram_read), 32'd0);
    check("rst_write", 32'(ram_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_mdr", mdr_out, 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // table-driven write/read pairs
    for (int i = 0; i < NV; i++) begin
      a = vecs[i].mar_bus[AW-1:0];
      load_mar(vecs[i].mar_bus);
      check("mar_trunc", 32'(ram_address), 32'(a));
      w0 = wr_cnt; r0 = rd_cnt;
      if (vecs[i].wr) begin
        load_mdr(vecs[i].data);
        ref_mem[a] = vecs[i].data;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, '0, lat);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_strobes", 32'(wr_cnt - w0), 32'd1);
        check("wr_no_read", 32'(rd_cnt - r0), 32'd0);
        check("wr_addr", 32'(wr_addr), 32'(a));
        check("wr_data", wr_data, vecs[i].data);
      end else begin
        load_mdr('0);
        check("mdr_clear", mdr_out, 32'd0);
        exp_q.push_back(ref_mem[a]);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, '0, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_strobes", 32'(rd_cnt - r0), 32'd1);
        check("rd_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rd_addr", 32'(rd_addr), 32'(a));
      end
      check("idle_busy", 32'(busy), 32'd0);
    end

    // simultaneous requests at the top address: write wins
    load_mar(32'h0000_01FF);
    load_mdr(32'h5A5A_0001);
    ref_mem[9'h1FF] = 32'h5A5A_0001;
    w0 = wr_cnt; r0 = rd_cnt;
    run_op(1'b1, 1'b1, 1'b0, 1'b0, '0, lat);
    check("sim_latency", 32'(lat), 32'd2);
    check("sim_wr", 32'(wr_cnt - w0), 32'd1);
    check("sim_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("sim_addr", 32'(wr_addr), 32'h1FF);

    // same-edge MAR+MDR load with write_req, then MDR load with read_req
    w0 = wr_cnt;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_50AB, lat);
    ref_mem[9'h0AB] = 32'h1234_50AB;
    check("same_wr_addr", 32'(wr_addr), 32'h0AB);
    check("same_wr_data", wr_data, 32'h1234_50AB);
    check("same_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    exp_q.push_back(ref_mem[9'h0AB]);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h7777_7777, lat);
    check("same_rd_latency", 32'(lat), 32'd3);

    // busy lockout during a read of 0x010
    load_mar(32'h10);
    load_mdr(32'hCAFE_0010);
    ref_mem[9'h010] = 32'hCAFE_0010;
    run_op(1'b1, 1'b0, 1'b0, 1'b0, '0, lat);
    load_mdr('0);
    exp_q.push_back(ref_mem[9'h010]);
    w0 = wr_cnt; r0 = rd_cnt;
    read_req = 1'b1;
    @(negedge clk);                 // RD_ISSUE
    read_req = 1'b0;
    bus_in = 32'h20; mar_in = 1'b1; mdr_in = 1'b1; write_req = 1'b1;
    check("lock_busy1", 32'(busy), 32'd1);
    @(negedge clk);                 // RD_CAPTURE
    mar_in = 1'b0; mdr_in = 1'b0; write_req = 1'b0;
    check("lock_mar", 32'(ram_address), 32'h010);
    check("lock_busy2", 32'(busy), 32'd1);
    @(negedge clk);                 // DONE
    check("lock_done", 32'(done), 32'd1);
    check("lock_busy3", 32'(busy), 32'd1);
    check("lock_mar2", 32'(ram_address), 32'h010);
    pop_check("lock_mdr");
    @(negedge clk);                 // IDLE
    check("lock_idle", 32'(busy), 32'd0);
    check("lock_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("lock_rd", 32'(rd_cnt - r0), 32'd1);

    // back-to-back: request in DONE ignored, request in IDLE accepted
    load_mar(32'h55);
    load_mdr('0);
    exp_q.push_back(ref_mem[9'h055]);
    exp_q.push_back(ref_mem[9'h055]);
    r0 = rd_cnt;
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    @(negedge clk);
    @(negedge clk);                 // DONE
    check("b2b_done1", 32'(done), 32'd1);
    pop_check("b2b_mdr1");
    read_req = 1'b1;
    @(negedge clk);                 // IDLE: DONE-edge request dropped
    check("b2b_ignored_state", 32'(state_dbg), 32'd0);
    check("b2b_ignored_read", 32'(ram_read), 32'd0);
    @(negedge clk);                 // accepted at the IDLE edge
    read_req = 1'b0;
    check("b2b_read2", 32'(ram_read), 32'd1);
    check("b2b_state2", 32'(state_dbg), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_done2", 32'(done), 32'd1);
    pop_check("b2b_mdr2");
    check("b2b_rd_cnt", 32'(rd_cnt - r0), 32'd2);
    @(negedge clk);

    // asynchronous reset in the middle of RD_ISSUE
    d0 = done_cnt;
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    check("mid_rd_issue", 32'(ram_read), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("mid_rst_read", 32'(ram_read), 32'd0);
    check("mid_rst_write", 32'(ram_write), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_addr", 32'(ram_address), 32'd0);
    check("mid_rst_mdr", mdr_out, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_idle", 32'(state_dbg), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
